biriscv_csr_wb: RTL and testbench
=================================

# biriscv_csr_wb

CSR writeback pipeline stage for the biRISC-V core; sits directly downstream of the CSR execute unit. Takes the registered E1 result (read value, write request, write data, exception code) and carries it through E2 into WB. At WB it produces the CSR-file write port and exception record (`csr_writeback_*`), plus the integer-register writeback for the CSR read value. It also handles stall, squash and a retired-CSR-instruction counter.

## Interface
- `EXCEPTION_W`, default 6: width of exception code; 0 means no exception.
- `EXC_ILLEGAL`, default 6'h12: code for illegal instruction (xtval = opcode).
- `EXC_BREAKPOINT`, default 6'h13: code for breakpoint (xtval = pc).
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `e1_valid_i` in 1: CSR-class instruction present in E1.
- `e1_pc_i` in 32: PC of E1 instruction.
- `e1_opcode_i` in 32: opcode of E1 instruction; bits [31:20] are the CSR address.
- `e1_rd_idx_i` in 5: destination integer register.
- `e1_value_i` in 32: CSR read value, or faulting opcode on exception.
- `e1_write_i` in 1: CSR write requested.
- `e1_wdata_i` in 32: CSR write data.
- `e1_exception_i` in EXCEPTION_W: E1 exception code.
- `stall_i` in 1: pipeline hold.
- `squash_i` in 1: kill E1 and E2 contents (older exception/branch).
- `wb_valid_o` out 1: instruction retires this cycle.
- `wb_rd_write_o` out 1: integer register write enable.
- `wb_rd_idx_o` out 5: integer register destination index.
- `wb_rd_value_o` out 32: integer register write value.
- `csr_writeback_write_o` out 1: CSR file write enable.
- `csr_writeback_waddr_o` out 12: CSR file write address.
- `csr_writeback_wdata_o` out 32: CSR file write data.
- `csr_writeback_exception_o` out EXCEPTION_W: exception code at WB.
- `csr_writeback_exception_pc_o` out 32: PC of the excepting instruction.
- `csr_writeback_exception_addr_o` out 32: xtval value for the exception.
- `retire_count_o` out 32: count of retired non-excepting CSR instructions.
- `fwd_valid_o` out 1: E2 forwarding-bus valid.
- `fwd_rd_idx_o` out 5: E2 forwarding destination index.
- `fwd_value_o` out 32: E2 forwarding value.

## Operation
- Two register stages, E2 and WB, each holding: valid, pc, rd_idx, csr addr, value, write, wdata, exception.
- E2 load:
  - `squash_i`=1: E2.valid <= 0 (priority over stall).
  - else `stall_i`=1: E2 holds.
  - else E2 <= E1 inputs, with valid = `e1_valid_i`.
- WB load:
  - `stall_i`=1 or `squash_i`=1: WB.valid <= 0 (bubble), so each instruction is written exactly once.
  - else WB <= E2.
- WB outputs, with V = WB.valid and X = (WB.exception != 0):
  - `wb_valid_o` = V.
  - `wb_rd_write_o` = V & ~X & (rd_idx != 0).
  - `csr_writeback_write_o` = V & ~X & write.
  - `csr_writeback_exception_o` = V ? exception : 0.
  - `csr_writeback_exception_pc_o` = pc.
  - `csr_writeback_exception_addr_o`:
    - value when exception == EXC_ILLEGAL;
    - pc when exception == EXC_BREAKPOINT;
    - 0 otherwise, including no exception.
  - `csr_writeback_waddr_o` = csr addr; `csr_writeback_wdata_o` = wdata; `wb_rd_value_o` = value.
- `retire_count_o` increments by 1 when V & ~X. It wraps from 32'hFFFF_FFFF to 0.
- Exceptions never update integer registers or CSRs. Flush of younger instructions is the consumer's job, via `squash_i`.

## Timing
- Latency: E1 inputs sampled at edge N appear on WB outputs after edge N+1 (two-cycle latency).
- Under a continuous unstalled stream, throughput is 1 per cycle.
- Reset values:
  - all valid bits 0; all outputs 0, including `retire_count_o`.
  - `csr_writeback_exception_o` = 0.
- Reset asserted mid-operation: all in-flight instructions are dropped; no write is emitted after reset release until new E1 input.
- `stall_i` and `squash_i` both high: squash wins; E2 is cleared and WB gets a bubble.
- `stall_i` held K cycles: E2 holds one instruction, WB emits K bubbles, and E2 advances on the first unstalled edge.
- `e1_valid_i`=0: E2 loads a bubble (unless stalled); data fields are don't-care but must not produce writes.

## Configuration
- `BIRISCV_CSR_WB_FWD_EN` defined:
  - `fwd_valid_o` = E2.valid & (E2.exception == 0) & (E2.rd_idx != 0).
  - `fwd_rd_idx_o` / `fwd_value_o` = E2 fields, for operand bypass to issue.
- Not defined: all three `fwd_*` outputs are tied to 0 and no forwarding logic is generated.

## Test plan
- CSR read with write, exception 0, unstalled: `e1_valid_i`=1, rd_idx=5, value=32'h1234, write=1, waddr=12'h300, wdata=32'h8 at edge N.
  - After edge N+1: `wb_rd_write_o`=1 with rd=5, value=32'h1234; `csr_writeback_write_o`=1 with waddr=12'h300, wdata=8.
  - `retire_count_o` reads 1 one cycle later.
- Illegal instruction: exception=EXC_ILLEGAL, value=32'hDEADBEEF, pc=32'h80000010.
  - WB: exception=12h, addr=32'hDEADBEEF, pc=32'h80000010.
  - No rd or CSR write; counter unchanged.
- Breakpoint: exception=EXC_BREAKPOINT, pc=32'h80000020 -> `csr_writeback_exception_addr_o`=32'h80000020.
- Stall: assert `stall_i` 3 cycles with one instruction in E2.
  - WB valid stays 0 for 3 cycles; the instruction then retires exactly once, 1 cycle after release.
- Squash with stall: `squash_i`=1 and `stall_i`=1 while instructions are in E2 -> neither ever retires; counter unchanged.
- Counter wrap: preload 32'hFFFF_FFFF via 2^32-1 retirements (or force in bench), retire one more -> `retire_count_o`=0.
- Forwarding, with and without `BIRISCV_CSR_WB_FWD_EN`: rd=0 or an excepting E2 gives `fwd_valid_o`=0.

Source files
------------

// File: rtl/biriscv_csr_wb.sv
// CSR writeback stage: carries the E1 CSR result through E2 into WB, driving the CSR-file write port,
// the exception record and the integer writeback. Optional E2 operand forwarding via BIRISCV_CSR_WB_FWD_EN.
module biriscv_csr_wb #(
    parameter int                     EXCEPTION_W    = 6,
    parameter logic [EXCEPTION_W-1:0] EXC_ILLEGAL    = 'h12,
    parameter logic [EXCEPTION_W-1:0] EXC_BREAKPOINT = 'h13
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   e1_valid_i,
    input  logic [31:0]            e1_pc_i,
    input  logic [31:0]            e1_opcode_i,
    input  logic [4:0]             e1_rd_idx_i,
    input  logic [31:0]            e1_value_i,
    input  logic                   e1_write_i,
    input  logic [31:0]            e1_wdata_i,
    input  logic [EXCEPTION_W-1:0] e1_exception_i,
    input  logic                   stall_i,
    input  logic                   squash_i,
    output logic                   wb_valid_o,
    output logic                   wb_rd_write_o,
    output logic [4:0]             wb_rd_idx_o,
    output logic [31:0]            wb_rd_value_o,
    output logic                   csr_writeback_write_o,
    output logic [11:0]            csr_writeback_waddr_o,
    output logic [31:0]            csr_writeback_wdata_o,
    output logic [EXCEPTION_W-1:0] csr_writeback_exception_o,
    output logic [31:0]            csr_writeback_exception_pc_o,
    output logic [31:0]            csr_writeback_exception_addr_o,
    output logic [31:0]            retire_count_o,
    output logic                   fwd_valid_o,
    output logic [4:0]             fwd_rd_idx_o,
    output logic [31:0]            fwd_value_o
);

    typedef struct packed {
        logic                   valid;
        logic [31:0]            pc;
        logic [4:0]             rd_idx;
        logic [11:0]            addr;
        logic [31:0]            value;
        logic                   write;
        logic [31:0]            wdata;
        logic [EXCEPTION_W-1:0] exception;
    } stage_t;

    stage_t      e1;
    stage_t      e2;
    stage_t      wb;
    logic [31:0] retire_count;
    logic        wb_ok;
    logic        unused_opcode;

    assign e1.valid     = e1_valid_i;
    assign e1.pc        = e1_pc_i;
    assign e1.rd_idx    = e1_rd_idx_i;
    assign e1.addr      = e1_opcode_i[31:20];
    assign e1.value     = e1_value_i;
    assign e1.write     = e1_write_i;
    assign e1.wdata     = e1_wdata_i;
    assign e1.exception = e1_exception_i;

    assign unused_opcode = ^e1_opcode_i[19:0];

    // Squash beats stall; a stalled cycle sends a bubble to WB so E2 retires exactly once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e2 <= '0;
            wb <= '0;
        end else begin
            if (squash_i)
                e2.valid <= 1'b0;
            else if (!stall_i)
                e2 <= e1;

            if (stall_i || squash_i)
                wb.valid <= 1'b0;
            else
                wb <= e2;
        end
    end

    assign wb_ok = wb.valid && (wb.exception == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            retire_count <= 32'd0;
        else if (wb_ok)
            retire_count <= retire_count + 32'd1;
    end

    assign wb_valid_o                   = wb.valid;
    assign wb_rd_write_o                = wb_ok && (wb.rd_idx != 5'd0);
    assign wb_rd_idx_o                  = wb.rd_idx;
    assign wb_rd_value_o                = wb.value;
    assign csr_writeback_write_o        = wb_ok && wb.write;
    assign csr_writeback_waddr_o        = wb.addr;
    assign csr_writeback_wdata_o        = wb.wdata;
    assign csr_writeback_exception_o    = wb.valid ? wb.exception : '0;
    assign csr_writeback_exception_pc_o = wb.pc;
    assign retire_count_o               = retire_count;

    // xtval: faulting opcode for illegal instructions, the PC for breakpoints.
    always_comb begin
        csr_writeback_exception_addr_o = 32'd0;
        if (wb.valid && wb.exception == EXC_ILLEGAL)
            csr_writeback_exception_addr_o = wb.value;
        else if (wb.valid && wb.exception == EXC_BREAKPOINT)
            csr_writeback_exception_addr_o = wb.pc;
    end

`ifdef BIRISCV_CSR_WB_FWD_EN
    assign fwd_valid_o  = e2.valid && (e2.exception == '0) && (e2.rd_idx != 5'd0);
    assign fwd_rd_idx_o = e2.rd_idx;
    assign fwd_value_o  = e2.value;
`else
    assign fwd_valid_o  = 1'b0;
    assign fwd_rd_idx_o = 5'd0;
    assign fwd_value_o  = 32'd0;
`endif

endmodule

// File: tb/tb_biriscv_csr_wb.sv
// Bench for biriscv_csr_wb: directed cases then random traffic, checked against an instruction-level model.
module tb_biriscv_csr_wb;

    localparam logic [5:0] EXC_ILL = 6'h12;
    localparam logic [5:0] EXC_BRK = 6'h13;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        e1_valid_i = 1'b0;
    logic [31:0] e1_pc_i = '0;
    logic [31:0] e1_opcode_i = '0;
    logic [4:0]  e1_rd_idx_i = '0;
    logic [31:0] e1_value_i = '0;
    logic        e1_write_i = 1'b0;
    logic [31:0] e1_wdata_i = '0;
    logic [5:0]  e1_exception_i = '0;
    logic        stall_i = 1'b0;
    logic        squash_i = 1'b0;
    logic        wb_valid_o, wb_rd_write_o, csr_writeback_write_o, fwd_valid_o;
    logic [4:0]  wb_rd_idx_o, fwd_rd_idx_o;
    logic [31:0] wb_rd_value_o, csr_writeback_wdata_o, csr_writeback_exception_pc_o;
    logic [31:0] csr_writeback_exception_addr_o, retire_count_o, fwd_value_o;
    logic [11:0] csr_writeback_waddr_o;
    logic [5:0]  csr_writeback_exception_o;

    biriscv_csr_wb dut (
        .clk(clk), .rst_n(rst_n),
        .e1_valid_i(e1_valid_i), .e1_pc_i(e1_pc_i), .e1_opcode_i(e1_opcode_i),
        .e1_rd_idx_i(e1_rd_idx_i), .e1_value_i(e1_value_i), .e1_write_i(e1_write_i),
        .e1_wdata_i(e1_wdata_i), .e1_exception_i(e1_exception_i),
        .stall_i(stall_i), .squash_i(squash_i),
        .wb_valid_o(wb_valid_o), .wb_rd_write_o(wb_rd_write_o), .wb_rd_idx_o(wb_rd_idx_o),
        .wb_rd_value_o(wb_rd_value_o), .csr_writeback_write_o(csr_writeback_write_o),
        .csr_writeback_waddr_o(csr_writeback_waddr_o), .csr_writeback_wdata_o(csr_writeback_wdata_o),
        .csr_writeback_exception_o(csr_writeback_exception_o),
        .csr_writeback_exception_pc_o(csr_writeback_exception_pc_o),
        .csr_writeback_exception_addr_o(csr_writeback_exception_addr_o),
        .retire_count_o(retire_count_o),
        .fwd_valid_o(fwd_valid_o), .fwd_rd_idx_o(fwd_rd_idx_o), .fwd_value_o(fwd_value_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          valid;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [11:0] addr;
        logic [31:0] value;
        bit          write;
        logic [31:0] wdata;
        logic [5:0]  exc;
    } inst_t;

    // Model: the instruction sitting one and two stages behind E1, plus the retirement tally.
    inst_t       m_e2, m_wb;
    logic [31:0] m_count;
    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] saved_count;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_e2 = '{default: '0};
        m_wb = '{default: '0};
        m_count = 32'd0;
    endtask

    task automatic model_advance();
        inst_t in;
        in.valid = e1_valid_i; in.pc = e1_pc_i; in.rd = e1_rd_idx_i; in.addr = e1_opcode_i[31:20];
        in.value = e1_value_i; in.write = e1_write_i; in.wdata = e1_wdata_i; in.exc = e1_exception_i;
        if (m_wb.valid && m_wb.exc == 6'd0) m_count = m_count + 32'd1;
        if (stall_i || squash_i) m_wb.valid = 1'b0;
        else m_wb = m_e2;
        if (squash_i) m_e2.valid = 1'b0;
        else if (!stall_i) m_e2 = in;
    endtask

    task automatic check_all();
        bit          v;
        bit          x;
        logic [31:0] xtval;
        v = m_wb.valid;
        x = (m_wb.exc != 6'd0);
        check("wb_valid", wb_valid_o, v);
        check("rd_write", wb_rd_write_o, v && !x && m_wb.rd != 5'd0);
        check("csr_write", csr_writeback_write_o, v && !x && m_wb.write);
        check("exception", csr_writeback_exception_o, v ? m_wb.exc : 6'd0);
        check("retire_count", retire_count_o, m_count);
        if (v) begin
            xtval = (m_wb.exc == EXC_ILL) ? m_wb.value : (m_wb.exc == EXC_BRK) ? m_wb.pc : 32'd0;
            check("rd_idx", wb_rd_idx_o, m_wb.rd);
            check("rd_value", wb_rd_value_o, m_wb.value);
            check("waddr", csr_writeback_waddr_o, m_wb.addr);
            check("wdata", csr_writeback_wdata_o, m_wb.wdata);
            check("exc_pc", csr_writeback_exception_pc_o, m_wb.pc);
            check("exc_addr", csr_writeback_exception_addr_o, xtval);
        end
`ifdef BIRISCV_CSR_WB_FWD_EN
        check("fwd_valid", fwd_valid_o, m_e2.valid && m_e2.exc == 6'd0 && m_e2.rd != 5'd0);
        if (m_e2.valid && m_e2.exc == 6'd0 && m_e2.rd != 5'd0) begin
            check("fwd_rd_idx", fwd_rd_idx_o, m_e2.rd);
            check("fwd_value", fwd_value_o, m_e2.value);
        end
`else
        check("fwd_valid", fwd_valid_o, 1'b0);
        check("fwd_rd_idx", fwd_rd_idx_o, 5'd0);
        check("fwd_value", fwd_value_o, 32'd0);
`endif
    endtask

    task automatic step();
        model_advance();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic drive(input bit valid, input logic [31:0] pc, input logic [11:0] addr,
                         input logic [4:0] rd, input logic [31:0] value, input bit write,
                         input logic [31:0] wdata, input logic [5:0] exc);
        e1_valid_i = valid; e1_pc_i = pc; e1_opcode_i = {addr, 20'($urandom)};
        e1_rd_idx_i = rd; e1_value_i = value; e1_write_i = write;
        e1_wdata_i = wdata; e1_exception_i = exc;
    endtask

    task automatic idle();
        drive(1'b0, 32'($urandom), 12'($urandom), 5'($urandom), 32'($urandom), 1'($urandom),
              32'($urandom), 6'd0);
    endtask

    function automatic logic [5:0] rand_exc();
        case ($urandom_range(0, 6))
            4: return EXC_ILL;
            5: return EXC_BRK;
            6: return 6'h02;
            default: return 6'd0;
        endcase
    endfunction

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;

        // Plain CSR read/write.
        drive(1'b1, 32'h8000_0000, 12'h300, 5'd5, 32'h1234, 1'b1, 32'h8, 6'd0);
        step();
        idle();
        step();
        check("first_rd_write", wb_rd_write_o, 1'b1);
        check("first_waddr", csr_writeback_waddr_o, 12'h300);
        step();
        check("first_count", retire_count_o, 32'd1);

        // Illegal instruction and breakpoint.
        drive(1'b1, 32'h8000_0010, 12'h305, 5'd7, 32'hDEAD_BEEF, 1'b1, 32'h55, EXC_ILL);
        step();
        drive(1'b1, 32'h8000_0020, 12'h341, 5'd9, 32'h7777, 1'b1, 32'h66, EXC_BRK);
        step();
        check("ill_xtval", csr_writeback_exception_addr_o, 32'hDEAD_BEEF);
        check("ill_no_csr_write", csr_writeback_write_o, 1'b0);
        idle();
        step();
        check("brk_xtval", csr_writeback_exception_addr_o, 32'h8000_0020);
        step();
        check("exc_count_unchanged", retire_count_o, 32'd1);

        // Three-cycle stall with an instruction parked in E2.
        drive(1'b1, 32'h8000_0030, 12'h340, 5'd3, 32'hAAAA, 1'b0, 32'h0, 6'd0);
        step();
        drive(1'b1, 32'h8000_0034, 12'h342, 5'd4, 32'hBBBB, 1'b1, 32'h1, 6'd0);
        stall_i = 1'b1;
        repeat (3) step();
        stall_i = 1'b0;
        idle();
        step();
        check("stall_release_pc", csr_writeback_exception_pc_o, 32'h8000_0030);
        step();
        check("stall_once", wb_valid_o, 1'b0);

        // Squash while stalled: nothing in flight retires.
        saved_count = retire_count_o;
        drive(1'b1, 32'h8000_0040, 12'h300, 5'd6, 32'hCCCC, 1'b1, 32'h2, 6'd0);
        step();
        drive(1'b1, 32'h8000_0044, 12'h300, 5'd8, 32'hDDDD, 1'b1, 32'h3, 6'd0);
        stall_i = 1'b1;
        squash_i = 1'b1;
        step();
        stall_i = 1'b0;
        squash_i = 1'b0;
        idle();
        repeat (3) step();
        check("squash_count", retire_count_o, saved_count);

        // Forwarding suppressed for rd=0 and for excepting instructions.
        drive(1'b1, 32'h8000_0050, 12'h300, 5'd0, 32'h1, 1'b0, 32'h0, 6'd0);
        step();
        check("fwd_rd0", fwd_valid_o, 1'b0);
        drive(1'b1, 32'h8000_0054, 12'h300, 5'd3, 32'h2, 1'b0, 32'h0, EXC_ILL);
        step();
        check("fwd_exc", fwd_valid_o, 1'b0);
        idle();
        repeat (2) step();

        // Counter wrap.
        force dut.retire_count = 32'hFFFF_FFFF;
        #1;
        release dut.retire_count;
        m_count = 32'hFFFF_FFFF;
        drive(1'b1, 32'h8000_0060, 12'h300, 5'd1, 32'h3, 1'b0, 32'h0, 6'd0);
        step();
        idle();
        step();
        step();
        check("wrap_zero", retire_count_o, 32'd0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 32'($urandom), 12'($urandom), 5'($urandom),
                  32'($urandom), 1'($urandom), 32'($urandom), rand_exc());
            stall_i  = ($urandom_range(0, 99) < 15);
            squash_i = ($urandom_range(0, 99) < 8);
            step();
        end
        stall_i = 1'b0;
        squash_i = 1'b0;

        // Reset with instructions in flight.
        drive(1'b1, 32'h8000_0070, 12'h300, 5'd2, 32'h4, 1'b1, 32'h5, 6'd0);
        step();
        step();
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
